// File: rtl/robin_alu.sv
// robin_alu: 32-bit single-cycle ALU for the robin CPU execute stage.
// Result and zero/negative flags are registered (latency 1, one op per cycle).
module robin_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] c,
    output logic             is_zero,
    output logic             is_negative
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_RSV2  = 4'd2,
        OP_RSV3  = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_NOT   = 4'd7,
        OP_CMP   = 4'd8,
        OP_TEST  = 4'd9,
        OP_CLZ   = 4'd10,
        OP_RSV11 = 4'd11,
        OP_SHL   = 4'd12,
        OP_SHR   = 4'd13,
        OP_MULLO = 4'd14,
        OP_MULHI = 4'd15
    } op_e;

    // Leading-zero count: counts zeros from the MSB until the first one bit;
    // an all-zero word yields 32.
    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (found) begin
                n = n;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + 6'd1;
            end
        end
        return n;
    endfunction

    logic [31:0] diff_s;
    logic [63:0] prod_s;
    logic        shamt_big_s;
    logic [31:0] f_s;
    logic [31:0] c_d, c_q;
    logic        zero_d, zero_q;
    logic        neg_d, neg_q;

    // Shared datapath pieces: wrapped difference, full 64-bit product, shift range test.
    always_comb begin
        diff_s      = a - b;
        prod_s      = {32'd0, a} * {32'd0, b};
        shamt_big_s = |b[31:5];
    end

    // Operation select; reserved codes produce zero.
    always_comb begin
        f_s = 32'd0;
        case (op_e'(op))
            OP_ADD:   f_s = a + b;
            OP_SUB:   f_s = diff_s;
            OP_AND:   f_s = a & b;
            OP_OR:    f_s = a | b;
            OP_XOR:   f_s = a ^ b;
            OP_NOT:   f_s = ~a;
            OP_CMP: begin
                if (diff_s == 32'd0) begin
                    f_s = 32'd0;
                end else if (diff_s[31]) begin
                    f_s = 32'hFFFF_FFFF;
                end else begin
                    f_s = 32'd1;
                end
            end
            OP_TEST:  f_s = a;
            OP_CLZ:   f_s = {26'd0, clz32(a)};
            OP_SHL: begin
                if (shamt_big_s) begin
                    f_s = 32'd0;
                end else begin
                    f_s = a << b[4:0];
                end
            end
            OP_SHR: begin
                if (shamt_big_s) begin
                    f_s = 32'd0;
                end else begin
                    f_s = a >> b[4:0];
                end
            end
            OP_MULLO: f_s = prod_s[31:0];
            OP_MULHI: f_s = prod_s[63:32];
            default:  f_s = 32'd0;
        endcase
    end

    // Next-state values for the result and the flags derived from it.
    always_comb begin
        c_d    = f_s;
        zero_d = (f_s == 32'd0);
        neg_d  = f_s[31];
    end

    // Output registers; asynchronous reset forces a zero result with zero flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q    <= 32'd0;
            zero_q <= 1'b1;
            neg_q  <= 1'b0;
        end else begin
            c_q    <= c_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign c           = c_q;
    assign is_zero     = zero_q;
    assign is_negative = neg_q;

endmodule

// File: tb/tb_robin_alu.sv
// Self-checking bench for robin_alu: expected results are queued when inputs
// are driven and compared one cycle later when the registered output appears.
module tb_robin_alu;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] c;
    logic        is_zero;
    logic        is_negative;

    typedef struct {
        logic [31:0] c;
        logic        z;
        logic        n;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;

    robin_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .op          (op),
        .c           (c),
        .is_zero     (is_zero),
        .is_negative (is_negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the ALU function.
    function automatic logic [31:0] ref_f(input logic [31:0] ra, input logic [31:0] rb,
                                          input logic [3:0] rop);
        logic [63:0] p;
        logic [31:0] d;
        logic [31:0] t;
        int          cnt;
        p = 64'(ra) * 64'(rb);
        d = ra - rb;
        case (rop)
            4'd0:  return ra + rb;
            4'd1:  return ra - rb;
            4'd4:  return ra & rb;
            4'd5:  return ra | rb;
            4'd6:  return ra ^ rb;
            4'd7:  return ~ra;
            4'd8:  begin
                if ($signed(d) < 0) return 32'hFFFF_FFFF;
                else if (d == 32'd0) return 32'd0;
                else return 32'd1;
            end
            4'd9:  return ra;
            4'd10: begin
                cnt = 0;
                t   = ra;
                while (cnt < 32 && t[31] == 1'b0) begin
                    t   = t << 1;
                    cnt = cnt + 1;
                end
                return 32'(cnt);
            end
            4'd12: return (rb >= 32'd32) ? 32'd0 : (ra << rb);
            4'd13: return (rb >= 32'd32) ? 32'd0 : (ra >> rb);
            4'd14: return p[31:0];
            4'd15: return p[63:32];
            default: return 32'd0;
        endcase
    endfunction

    // Drive one operation, push its expectation, then pop and compare after the edge.
    task automatic step(input logic [31:0] sa, input logic [31:0] sb_in, input logic [3:0] sop,
                        input logic [31:0] exp_c, input string tag);
        exp_t e;
        exp_t g;
        @(negedge clk);
        a  = sa;
        b  = sb_in;
        op = sop;
        e.c   = exp_c;
        e.z   = (exp_c == 32'd0);
        e.n   = exp_c[31];
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            g = sb.pop_front();
            if ({c, is_zero, is_negative} !== {g.c, g.z, g.n}) begin
                tests_failed++;
                $display("FAIL %s: a=%h b=%h op=%0d got c=%h z=%b n=%b expected c=%h z=%b n=%b",
                         g.tag, sa, sb_in, sop, c, is_zero, is_negative, g.c, g.z, g.n);
            end
        end
    endtask

    task automatic test_reset();
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
        op    = 4'd0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({c, is_zero, is_negative} !== {32'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_async: got c=%h z=%b n=%b expected c=00000000 z=1 n=0",
                     c, is_zero, is_negative);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({c, is_zero, is_negative} !== {32'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_hold: got c=%h z=%b n=%b expected c=00000000 z=1 n=0",
                     c, is_zero, is_negative);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add_sub();
        step(32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, "add_wrap");
        step(32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, "sub_wrap");
        step(32'd100, 32'd23, 4'd0, 32'd123, "add_basic");
        step(32'd100, 32'd23, 4'd1, 32'd77, "sub_basic");
    endtask

    task automatic test_logic();
        step(32'hF0F0_1234, 32'h0FF0_FFFF, 4'd4, 32'h00F0_1234, "and");
        step(32'hF000_0000, 32'h0000_000F, 4'd5, 32'hF000_000F, "or");
        step(32'hFFFF_0000, 32'hFF00_FF00, 4'd6, 32'h00FF_FF00, "xor");
        step(32'hFFFF_FFFF, 32'h1234_5678, 4'd7, 32'd0, "not_all_ones");
    endtask

    task automatic test_cmp();
        step(32'd5, 32'd5, 4'd8, 32'd0, "cmp_eq");
        step(32'd3, 32'd7, 4'd8, 32'hFFFF_FFFF, "cmp_lt");
        step(32'd7, 32'd3, 4'd8, 32'd1, "cmp_gt");
        step(32'h8000_0000, 32'd1, 4'd8, 32'd1, "cmp_wrapdiff");
    endtask

    task automatic test_clz_test();
        step(32'd0, 32'd0, 4'd10, 32'd32, "clz_zero");
        step(32'h0001_0000, 32'd0, 4'd10, 32'd15, "clz_bit16");
        step(32'h8000_0000, 32'd0, 4'd10, 32'd0, "clz_msb");
        step(32'h0000_0001, 32'd0, 4'd10, 32'd31, "clz_lsb");
        step(32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 32'h8000_0000, "test_neg");
        step(32'd0, 32'h5555_5555, 4'd9, 32'd0, "test_zero");
    endtask

    task automatic test_shift();
        step(32'h8000_0001, 32'd1, 4'd12, 32'h0000_0002, "shl_1");
        step(32'h8000_0001, 32'd31, 4'd13, 32'h0000_0001, "shr_31");
        step(32'h8000_0001, 32'd32, 4'd12, 32'd0, "shl_32");
        step(32'h8000_0001, 32'd32, 4'd13, 32'd0, "shr_32");
        step(32'h8000_0001, 32'd0, 4'd13, 32'h8000_0001, "shr_0");
        step(32'hFFFF_FFFF, 32'h0000_0101, 4'd12, 32'd0, "shl_big");
        step(32'h0000_0001, 32'd31, 4'd12, 32'h8000_0000, "shl_31");
    endtask

    task automatic test_mul();
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd14, 32'h0000_0001, "mullo_max");
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'hFFFF_FFFE, "mulhi_max");
        step(32'h0001_0000, 32'h0001_0000, 4'd14, 32'd0, "mullo_2p32");
        step(32'h0001_0000, 32'h0001_0000, 4'd15, 32'd1, "mulhi_2p32");
    endtask

    task automatic test_reserved();
        step(32'hFFFF_FFFF, 32'h1234_5678, 4'd2, 32'd0, "rsv2");
        step(32'h8000_0000, 32'h8000_0000, 4'd3, 32'd0, "rsv3");
        step(32'h7FFF_FFFF, 32'd9, 4'd11, 32'd0, "rsv11");
    endtask

    task automatic test_random_per_op();
        logic [3:0]  ops [13];
        logic [31:0] ra;
        logic [31:0] rb;
        ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14, 4'd15};
        for (int k = 0; k < 13; k++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom;
                rb = $urandom;
                if (ops[k] == 4'd12 || ops[k] == 4'd13) begin
                    if ($urandom_range(0, 1) == 0) rb = 32'($urandom_range(0, 40));
                end
                if (ops[k] == 4'd10) ra = ra >> $urandom_range(0, 32);
                step(ra, rb, ops[k], ref_f(ra, rb, ops[k]), "rand_op");
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;
        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            rop = 4'($urandom_range(0, 15));
            step(ra, rb, rop, ref_f(ra, rb, rop), "b2b");
        end
    endtask

    task automatic test_reset_midstream();
        step(32'h8000_0000, 32'd0, 4'd9, 32'h8000_0000, "pre_reset");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({c, is_zero, is_negative} !== {32'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid: got c=%h z=%b n=%b expected c=00000000 z=1 n=0",
                     c, is_zero, is_negative);
        end
        @(negedge clk);
        reset = 1'b0;
        step(32'd40, 32'd2, 4'd0, 32'd42, "post_reset_first");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add_sub();
        test_logic();
        test_cmp();
        test_clz_test();
        test_shift();
        test_mul();
        test_reserved();
        test_random_per_op();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
